// File: rtl/uart_rx_checked.sv
// uart_rx_checked: 8N1 UART receiver with mid-bit sampling, start-bit glitch
// rejection and framing-error detection. After a framing error or a break the
// receiver waits for the line to return high before it re-arms.
module uart_rx_checked #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Frame_Err,
  output logic       o_RX_Active
);

  // Counter is just wide enough to reach CLKS_PER_BIT-1.
  localparam int CNT_W = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  logic             sync_1;
  logic             rx_s;

  state_t           state,      state_next;
  logic [CNT_W-1:0] count,      count_next;
  logic [2:0]       index,      index_next;
  logic [7:0]       shift,      shift_next;
  logic [7:0]       byte_reg,   byte_next;
  logic             dv,         dv_next;
  logic             frame_err,  frame_err_next;
  logic             active,     active_next;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= i_RX_Serial;
      rx_s   <= sync_1;
    end
  end

  // State register and all registered datapath/outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      count     <= '0;
      index     <= '0;
      shift     <= '0;
      byte_reg  <= '0;
      dv        <= 1'b0;
      frame_err <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      index     <= index_next;
      shift     <= shift_next;
      byte_reg  <= byte_next;
      dv        <= dv_next;
      frame_err <= frame_err_next;
      active    <= active_next;
    end
  end

  // Next-state and next-output logic; pulses default low so they last one cycle.
  always_comb begin
    state_next     = state;
    count_next     = count;
    index_next     = index;
    shift_next     = shift;
    byte_next      = byte_reg;
    dv_next        = 1'b0;
    frame_err_next = 1'b0;
    active_next    = active;

    case (state)
      IDLE: begin
        count_next  = '0;
        index_next  = '0;
        active_next = 1'b0;
        if (!rx_s) begin
          state_next  = START;
          active_next = 1'b1;
        end
      end

      START: begin
        if (count < HALF_CNT) begin
          count_next = count + 1'b1;
        end else if (!rx_s) begin
          state_next = DATA;
          count_next = '0;
          index_next = '0;
        end else begin
          state_next  = IDLE;
          count_next  = '0;
          active_next = 1'b0;
        end
      end

      DATA: begin
        if (count < LAST_CNT) begin
          count_next = count + 1'b1;
        end else begin
          count_next        = '0;
          shift_next[index] = rx_s;
          if (index < 3'd7) begin
            index_next = index + 1'b1;
          end else begin
            index_next = '0;
            state_next = STOP;
          end
        end
      end

      STOP: begin
        if (count < LAST_CNT) begin
          count_next = count + 1'b1;
        end else begin
          count_next  = '0;
          active_next = 1'b0;
          if (rx_s) begin
            byte_next  = shift;
            dv_next    = 1'b1;
            state_next = CLEANUP;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_HIGH;
          end
        end
      end

      CLEANUP: begin
        state_next = IDLE;
      end

      WAIT_HIGH: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next  = IDLE;
        count_next  = '0;
        index_next  = '0;
        active_next = 1'b0;
      end
    endcase
  end

  assign o_RX_DV        = dv;
  assign o_RX_Byte      = byte_reg;
  assign o_RX_Frame_Err = frame_err;
  assign o_RX_Active    = active;

endmodule

// File: tb/tb_uart_rx_checked.sv
// Directed testbench for uart_rx_checked with CLKS_PER_BIT=16.
`timescale 1ns/1ps
module tb_uart_rx_checked;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_line;
  logic       dv;
  logic [7:0] rx_byte;
  logic       frame_err;
  logic       active;

  int total = 0;
  int bad = 0;
  int edge_count = 0;
  int frame_start = 0;

  int dv_edges[$];
  int dv_bytes[$];
  int err_edges[$];
  int dv_high_count = 0;
  int err_high_count = 0;
  int overlap_count = 0;
  int bad_byte_change = 0;
  int active_rise_at = -1;
  int active_fall_at = -1;
  logic       prev_active = 1'b0;
  logic       prev_dv = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  uart_rx_checked #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Rst_L        (rst_n),
    .i_RX_Serial    (rx_line),
    .o_RX_DV        (dv),
    .o_RX_Byte      (rx_byte),
    .o_RX_Frame_Err (frame_err),
    .o_RX_Active    (active)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Edge counter used as a timestamp for everything the monitor records.
  always @(posedge clk) edge_count <= edge_count + 1;

  // Monitor sampling outputs mid-cycle, logging pulses and protocol violations.
  always @(negedge clk) begin
    if (dv) dv_high_count++;
    if (frame_err) err_high_count++;
    if (dv && frame_err) overlap_count++;
    if (dv && !prev_dv) begin
      dv_edges.push_back(edge_count);
      dv_bytes.push_back(int'(rx_byte));
    end
    if (frame_err && !prev_err) err_edges.push_back(edge_count);
    if (active && !prev_active) active_rise_at = edge_count;
    if (!active && prev_active) active_fall_at = edge_count;
    if (rst_n && !dv && rx_byte !== prev_byte) bad_byte_change++;
    prev_dv     = dv;
    prev_err    = frame_err;
    prev_active = active;
    prev_byte   = rx_byte;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic int dvByteAt(input int i);
    if (i < dv_bytes.size()) return dv_bytes[i];
    return -1;
  endfunction

  function automatic int dvEdgeAt(input int i);
    if (i < dv_edges.size()) return dv_edges[i];
    return -1000;
  endfunction

  function automatic int errEdgeAt(input int i);
    if (i < err_edges.size()) return err_edges[i];
    return -1000;
  endfunction

  task automatic driveBit(input logic val, input int period);
    rx_line = val;
    repeat (period) @(negedge clk);
  endtask

  task automatic idleLine(input int cycles);
    rx_line = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  // Sends one 8N1 frame starting at a negedge; frame_start marks the line drop.
  task automatic applyStimulus(input logic [7:0] data, input int period, input logic stop_val);
    frame_start = edge_count;
    driveBit(1'b0, period);
    for (int i = 0; i < 8; i++) driveBit(data[i], period);
    driveBit(stop_val, period);
  endtask

  initial begin
    int n0;
    int e0;
    int fs;
    logic [7:0] mid_data;

    rst_n   = 1'b0;
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reset_dv", 32'(dv), 32'h0);
    checkOutput("reset_err", 32'(frame_err), 32'h0);
    checkOutput("reset_active", 32'(active), 32'h0);
    checkOutput("reset_byte", 32'(rx_byte), 32'h00);
    rst_n = 1'b1;
    idleLine(20);

    $display("[TB] single frame A5");
    n0 = dv_bytes.size();
    applyStimulus(8'hA5, CPB, 1'b1);
    idleLine(20);
    checkOutput("a5_count", 32'(dv_bytes.size() - n0), 32'd1);
    checkOutput("a5_byte", 32'(dvByteAt(n0)), 32'hA5);
    checkOutput("a5_dv_time", 32'(dvEdgeAt(n0) - frame_start), 32'd155);
    checkOutput("a5_active_rise", 32'(active_rise_at - frame_start), 32'd3);
    checkOutput("a5_active_fall", 32'(active_fall_at - frame_start), 32'd155);
    checkOutput("a5_out_byte", 32'(rx_byte), 32'hA5);
    checkOutput("a5_no_err", 32'(err_edges.size()), 32'd0);

    $display("[TB] back-to-back 00 FF 55");
    n0 = dv_bytes.size();
    applyStimulus(8'h00, CPB, 1'b1);
    applyStimulus(8'hFF, CPB, 1'b1);
    applyStimulus(8'h55, CPB, 1'b1);
    idleLine(20);
    checkOutput("b2b_count", 32'(dv_bytes.size() - n0), 32'd3);
    checkOutput("b2b_byte0", 32'(dvByteAt(n0)), 32'h00);
    checkOutput("b2b_byte1", 32'(dvByteAt(n0 + 1)), 32'hFF);
    checkOutput("b2b_byte2", 32'(dvByteAt(n0 + 2)), 32'h55);
    checkOutput("b2b_gap01", 32'(dvEdgeAt(n0 + 1) - dvEdgeAt(n0)), 32'd160);
    checkOutput("b2b_gap12", 32'(dvEdgeAt(n0 + 2) - dvEdgeAt(n0 + 1)), 32'd160);

    $display("[TB] start glitch");
    n0 = dv_bytes.size();
    e0 = err_edges.size();
    fs = edge_count;
    rx_line = 1'b0;
    repeat (5) @(negedge clk);
    idleLine(40);
    checkOutput("glitch_no_dv", 32'(dv_bytes.size() - n0), 32'd0);
    checkOutput("glitch_no_err", 32'(err_edges.size() - e0), 32'd0);
    checkOutput("glitch_active_rise", 32'(active_rise_at - fs), 32'd3);
    checkOutput("glitch_active_fall", 32'(active_fall_at - fs), 32'd11);
    applyStimulus(8'h3C, CPB, 1'b1);
    idleLine(20);
    checkOutput("after_glitch_byte", 32'(dvByteAt(n0)), 32'h3C);

    $display("[TB] framing error and break");
    n0 = dv_bytes.size();
    e0 = err_edges.size();
    applyStimulus(8'h81, CPB, 1'b0);
    repeat (500) @(negedge clk);
    idleLine(40);
    checkOutput("ferr_count", 32'(err_edges.size() - e0), 32'd1);
    checkOutput("ferr_time", 32'(errEdgeAt(e0) - frame_start), 32'd155);
    checkOutput("ferr_no_dv", 32'(dv_bytes.size() - n0), 32'd0);
    checkOutput("ferr_byte_kept", 32'(rx_byte), 32'h3C);
    applyStimulus(8'h42, CPB, 1'b1);
    idleLine(20);
    checkOutput("after_ferr_byte", 32'(dvByteAt(n0)), 32'h42);

    $display("[TB] reset mid-frame");
    mid_data = 8'hF0;
    driveBit(1'b0, CPB);
    for (int i = 0; i < 4; i++) driveBit(mid_data[i], CPB);
    rx_line = mid_data[4];
    repeat (8) @(negedge clk);
    checkOutput("mid_active", 32'(active), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_active", 32'(active), 32'h0);
    checkOutput("async_rst_byte", 32'(rx_byte), 32'h00);
    checkOutput("async_rst_dv", 32'(dv), 32'h0);
    checkOutput("async_rst_err", 32'(frame_err), 32'h0);
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    n0 = dv_bytes.size();
    idleLine(200);
    checkOutput("post_rst_no_dv", 32'(dv_bytes.size() - n0), 32'd0);
    applyStimulus(8'h0F, CPB, 1'b1);
    idleLine(20);
    checkOutput("post_rst_byte", 32'(dvByteAt(n0)), 32'h0F);

    $display("[TB] baud skew");
    n0 = dv_bytes.size();
    applyStimulus(8'hC3, 15, 1'b1);
    idleLine(60);
    applyStimulus(8'hC3, 17, 1'b1);
    idleLine(60);
    checkOutput("skew_count", 32'(dv_bytes.size() - n0), 32'd2);
    checkOutput("skew_fast_byte", 32'(dvByteAt(n0)), 32'hC3);
    checkOutput("skew_slow_byte", 32'(dvByteAt(n0 + 1)), 32'hC3);

    checkOutput("total_frames", 32'(dv_bytes.size()), 32'd9);
    checkOutput("dv_high_cycles", 32'(dv_high_count), 32'd9);
    checkOutput("err_high_cycles", 32'(err_high_count), 32'd1);
    checkOutput("dv_err_overlap", 32'(overlap_count), 32'd0);
    checkOutput("byte_change_without_dv", 32'(bad_byte_change), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_checked.md
Name: uart_rx_checked

Overview:
- Receive side of the 8N1 UART link: 8 data bits LSB first, one start bit, one stop bit, no parity.
- Deserialises the line with mid-bit sampling, rejects start-bit glitches, and flags framing errors.
- Waits for the line to return high after a break or framing error before re-arming.
- Sits between the board RX pin and the consumer logic, mirroring the transmitter on the far end.

Parameters:
CLKS_PER_BIT, 217, i_Clock cycles per UART bit (clock freq / baud); legal range 4..65535.

Ports:
i_Clock  input  1  system clock, all logic on rising edge
i_Rst_L  input  1  asynchronous active-low reset
i_RX_Serial  input  1  asynchronous serial line, idle high
o_RX_DV  output  1  one-cycle pulse: o_RX_Byte holds a new valid byte
o_RX_Byte  output  8  last correctly framed byte received
o_RX_Frame_Err  output  1  one-cycle pulse: stop bit sampled low
o_RX_Active  output  1  high while a frame is in progress (START through STOP)

Behaviour:
- Reset (i_Rst_L low, asynchronous, any state including mid-frame):
  - o_RX_DV=0, o_RX_Frame_Err=0, o_RX_Active=0, o_RX_Byte=8'h00.
  - State=IDLE, counters=0, both synchroniser flops=1.
  - Deassertion is sampled on i_Clock.
- Input synchroniser: i_RX_Serial passes through a 2-flop synchroniser; all decisions use the 2nd flop (rx_s).
- Counters:
  - Clock counter width = clog2(CLKS_PER_BIT), minimum 1.
  - Bit index is 3 bits.
  - H = (CLKS_PER_BIT-1)/2, integer division.
- IDLE:
  - Outputs DV/Err low.
  - rx_s==0 -> START, count=0, Active=1.
- START:
  - count<H -> count+1.
  - count==H and rx_s==0 -> DATA, count=0, index=0.
  - count==H and rx_s==1 -> glitch: IDLE, Active=0, no pulse.
- DATA:
  - count<CLKS_PER_BIT-1 -> count+1.
  - Otherwise sample rx_s into shift reg bit[index], count=0.
  - index<7 -> index+1; index==7 -> STOP.
- STOP:
  - At count==CLKS_PER_BIT-1 sample rx_s, then Active=0 and count=0.
  - rx_s==1: o_RX_Byte<=shift reg, o_RX_DV=1 for one cycle -> CLEANUP.
  - rx_s==0: o_RX_Frame_Err=1 for one cycle, o_RX_Byte unchanged -> WAIT_HIGH.
- CLEANUP: one cycle, pulses drop -> IDLE.
- WAIT_HIGH: stay until rx_s==1 -> IDLE. A line held low (break) produces exactly one Frame_Err and no further frames.
- Timing: edge 0 is the first i_Clock edge registering i_RX_Serial low. Stop sample, and the edge raising o_RX_DV/o_RX_Frame_Err, is edge 3+H+9*CLKS_PER_BIT.
- Back-to-back frames:
  - Stop is sampled mid-bit, so IDLE is re-entered ~half a bit early.
  - A next start bit beginning immediately after the stop bit must be received with no loss.
- Exclusivity:
  - o_RX_DV and o_RX_Frame_Err are never high together.
  - Each is high for exactly one cycle per frame.
  - o_RX_Byte only changes on the edge raising o_RX_DV.
- Unused state encodings -> IDLE.

Test Plan:
- CLKS_PER_BIT=16 (H=7): send 8'hA5, ideal timing, stop=1 -> o_RX_DV high for 1 cycle at edge 154, o_RX_Byte=8'hA5, Frame_Err never high, Active high edges 3..154.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap -> three DV pulses, bytes in order, spaced 160 cycles.
- Low glitch of 5 cycles on idle line -> no DV, no Frame_Err, Active pulses then returns to 0 by edge 11, next 8'h3C received correctly.
- Frame 8'h81 with stop bit driven 0, line then held low 500 cycles -> one Frame_Err pulse, o_RX_Byte keeps prior value, no DV. After the line goes high, 8'h42 is received correctly.
- Reset asserted mid-DATA (bit 4 of 8'hF0) -> all outputs 0 immediately (asynchronous, before next clock). After release with the line idle, no spurious DV; next 8'h0F received.
- Baud skew: 8'hC3 with bit period 15 cycles, then 17 cycles, receiver CLKS_PER_BIT=16 -> both received as 8'hC3 with DV.
